mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single-port unified memory between the instruction-fetch stage and the data-memory stage (LW, LWPOI, SW, PUSH, POP, CALL, RET stack traffic) of the multi-cycle core. It accepts held requests from both stages and grants one at a time. It drives one memory access per grant and waits a fixed memory read latency. It then returns read data with a one-cycle done pulse, so the control unit stalls its stage until completion.

## Interface
- ADDR_W, 16, word-address width
- DATA_W, 16, data word width
- MEM_LAT, 2, memory read latency in cycles from mem_en to valid mem_rdata; legal range is ≥1
- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch read request, held until f_done
- f_addr  in  ADDR_W  fetch address (PC), stable while f_req high
- f_gnt  out  1  one-cycle pulse: fetch request accepted
- f_done  out  1  one-cycle pulse: f_rdata valid
- f_rdata  out  DATA_W  fetched instruction word, held until next fetch completion
- d_req  in  1  data request, held until d_done
- d_we  in  1  1 = write, 0 = read; stable while d_req high
- d_addr  in  ADDR_W  data address (ALU result or SP)
- d_wdata  in  DATA_W  store data (register or return address)
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_done  out  1  one-cycle pulse: access complete; d_rdata valid if read
- d_rdata  out  DATA_W  load/pop data, held until next data read completion
- mem_en  out  1  memory access strobe, exactly one cycle per grant
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE: if f_req or d_req is sampled high, pick a winner, capture addr/we/wdata/owner, and go to ISSUE. Otherwise stay in IDLE.
- Fetch accesses are always reads; mem_we = 0 for fetch.
- Arbitration with both requests high (default): data wins (fixed priority, older instruction).
- ISSUE (1 cycle): mem_en = 1, mem_we/mem_addr/mem_wdata from captured values; winner's gnt = 1. Load the latency counter with MEM_LAT and go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter reaches 1 (mem_rdata valid), latch mem_rdata into the owner's rdata register if the access is a read. Then go to DONE.
- DONE (1 cycle): owner's done = 1. Requests are ignored in this state. Go to IDLE next cycle.
- Writes use the same timing as reads. A write never updates d_rdata.
- A request arriving while busy waits, held, until IDLE. Requests never queue internally.
- If a requester drops req after gnt (protocol violation), the access still completes and done still pulses.
- Outside ISSUE: mem_en = 0 and mem_we = 0; mem_addr and mem_wdata hold their last value.

## Timing
- Request sampled in IDLE at cycle T gives ISSUE/gnt at T+1, mem_rdata sampled at T+1+MEM_LAT, done at T+2+MEM_LAT, IDLE at T+3+MEM_LAT.
- Back-to-back throughput: one access per MEM_LAT+3 cycles. Requester must drop req in the cycle after done to avoid re-grant.
- Reset (async, any state): state = IDLE. f_gnt, f_done, d_gnt, d_done, mem_en, mem_we, busy = 0. mem_addr, mem_wdata, f_rdata, d_rdata = 0. RR pointer = "last served data".
- Reset mid-access aborts it: no done pulse; the requester must re-issue after reset release.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a tie, grant the port not served most recently. The one-bit last-served pointer updates in ISSUE. After reset, fetch wins the first tie.
- Undefined: fixed data-over-fetch priority; no pointer register.

## Test plan
- Single fetch: MEM_LAT=2, f_req at T with f_addr=0x0010, memory returns 0xABCD. Required: f_gnt at T+1, mem_en=1/mem_we=0/mem_addr=0x0010 at T+1, f_done with f_rdata=0xABCD at T+4, busy low at T+5.
- Data write: d_req, d_we=1, d_addr=0x00FF, d_wdata=0x1234. Required: mem_en=1, mem_we=1, mem_wdata=0x1234 for exactly one cycle; d_done at T+4; d_rdata unchanged.
- Simultaneous requests, macro undefined: data served first, fetch granted in the cycle after the data IDLE re-entry. Macro defined: the first tie goes to fetch, the second tie to data.
- Held request during busy: f_req rises in WAIT of a data access. Required: no f_gnt until IDLE, then normal fetch timing.
- Reset mid-access: assert reset_n=0 during WAIT. Required: all outputs 0 immediately, no done pulse; a new request after release completes normally.
- MEM_LAT=1 and MEM_LAT=4 builds: done exactly MEM_LAT+2 cycles after request sampled, rdata correct.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and data access.
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate between ports instead of data always winning.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_done,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              wr_q, wr_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              f_gnt_q, f_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              f_done_q, f_done_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;
    logic              grant_data_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_data_q, last_data_d;

    // Tie goes to the port that was not served most recently
    always_comb begin
        if (f_req && d_req) begin
            grant_data_s = ~last_data_q;
        end else begin
            grant_data_s = d_req;
        end
    end

    // Last-served pointer advances when an access is issued
    always_comb begin
        if (state_q == ST_ISSUE) begin
            last_data_d = owner_q;
        end else begin
            last_data_d = last_data_q;
        end
    end

    // Pointer register; reset value makes fetch win the first tie
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_data_q <= 1'b1;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`else
    // Fixed priority: a pending data access belongs to the older instruction
    always_comb begin
        grant_data_s = d_req;
    end
`endif

    // Next-state and registered-output logic of the access sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        f_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        f_done_d    = 1'b0;
        d_done_d    = 1'b0;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (f_req || d_req) begin
                    state_d  = ST_ISSUE;
                    owner_d  = grant_data_s;
                    mem_en_d = 1'b1;
                    if (grant_data_s) begin
                        wr_d        = d_we;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        d_gnt_d     = 1'b1;
                    end else begin
                        wr_d       = 1'b0;
                        mem_addr_d = f_addr;
                        f_gnt_d    = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(MEM_LAT);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Counter at one means mem_rdata is valid this cycle
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    if (!wr_q && owner_q) begin
                        d_rdata_d = mem_rdata;
                    end else if (!wr_q) begin
                        f_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                    if (owner_q) begin
                        d_done_d = 1'b1;
                    end else begin
                        f_done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            wr_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            f_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            f_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            f_gnt_q     <= f_gnt_d;
            d_gnt_q     <= d_gnt_d;
            f_done_q    <= f_done_d;
            d_done_q    <= d_done_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign f_gnt     = f_gnt_q;
    assign f_done    = f_done_q;
    assign f_rdata   = f_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule
